// File: rtl/vga_draw_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_draw_ctrl_if
//
// Purpose
//   Bundles the two buses of the draw-command sequencer into one interface:
//     * the command handshake from the UART command decoder
//       (cmd_valid / cmd_ready plus the command payload), and
//     * the framebuffer back-buffer write port and swap handshake
//       (mem_addr / din / wen / swap_buf / swap_done).
//
// Modports
//   master : the side that issues commands and owns the framebuffer.
//            Drives cmd_* and swap_done; observes cmd_ready, mem_addr,
//            din, wen and swap_buf.
//   slave  : the sequencer (vga_draw_ctrl). Mirror image of master.
//
// Parameters
//   X_BITS, Y_BITS : coordinate widths. The command coordinates carry one
//                    extra bit so that values past the edge can be detected.
//   MEM_WIDTH      : pixel word width (colour format 0b00RRGGBB).
//   ADDR_WIDTH     : framebuffer address width.
//   The defaults match a 320x240 framebuffer with 8-bit pixels.
// ---------------------------------------------------------------------------
interface vga_draw_ctrl_if #(
    parameter int X_BITS     = 9,
    parameter int Y_BITS     = 8,
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 17
);
    // Command handshake and payload
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [X_BITS:0]       cmd_x0;
    logic [Y_BITS:0]       cmd_y0;
    logic [X_BITS:0]       cmd_x1;
    logic [Y_BITS:0]       cmd_y1;
    logic [MEM_WIDTH-1:0]  cmd_color;

    // Framebuffer write port and swap handshake
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  din;
    logic                  wen;
    logic                  swap_buf;
    logic                  swap_done;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_x0,
        output cmd_y0,
        output cmd_x1,
        output cmd_y1,
        output cmd_color,
        output swap_done,
        input  cmd_ready,
        input  mem_addr,
        input  din,
        input  wen,
        input  swap_buf
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_x0,
        input  cmd_y0,
        input  cmd_x1,
        input  cmd_y1,
        input  cmd_color,
        input  swap_done,
        output cmd_ready,
        output mem_addr,
        output din,
        output wen,
        output swap_buf
    );
endinterface

// File: rtl/vga_draw_ctrl.sv
// ---------------------------------------------------------------------------
// vga_draw_ctrl
//
// Purpose
//   Draw-command sequencer in front of the double-buffered VGA framebuffer.
//   Accepts CLEAR / PIXEL / RECT / SWAP commands over a valid/ready
//   handshake and expands the drawing commands into one back-buffer write
//   per cycle in raster order (x fastest). A SWAP command raises a one-cycle
//   swap request and then holds off further commands until the framebuffer
//   reports that the swap has been taken.
//
// Ports
//   clk      : system clock
//   rst      : asynchronous, active-low reset
//   bus      : vga_draw_ctrl_if.slave
//                cmd_valid/cmd_ready/cmd_op/cmd_x0/cmd_y0/cmd_x1/cmd_y1/
//                cmd_color  - command handshake from the UART decoder
//                mem_addr/din/wen - registered back-buffer write port
//                swap_buf   - one-cycle swap request
//                swap_done  - one-cycle swap-taken pulse from framebuffer
//   busy     : high whenever the sequencer is not idle
//   cmd_err  : one-cycle pulse when a command is rejected
//
// Configuration
//   VGA_DRAW_CLIP_EN : when defined, out-of-range coordinates are clamped to
//                      the last column/row and the command executes. When
//                      undefined (default), a PIXEL or RECT with any
//                      coordinate past the edge is rejected with cmd_err and
//                      nothing is written.
// ---------------------------------------------------------------------------
module vga_draw_ctrl #(
    parameter int RES_X      = 320,
    parameter int RES_Y      = 240,
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = $clog2(RES_X * RES_Y),
    parameter int X_BITS     = $clog2(RES_X),
    parameter int Y_BITS     = $clog2(RES_Y)
) (
    input  logic            clk,
    input  logic            rst,
    vga_draw_ctrl_if.slave  bus,
    output logic            busy,
    output logic            cmd_err
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_SWAP_REQ  = 2'd2,
        ST_SWAP_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_PIXEL = 2'd1,
        OP_RECT  = 2'd2,
        OP_SWAP  = 2'd3
    } op_t;

    // Last valid column/row, both at the internal width and at the wider
    // command width used for range checks.
    localparam logic [X_BITS-1:0]     X_LAST   = X_BITS'(RES_X - 1);
    localparam logic [Y_BITS-1:0]     Y_LAST   = Y_BITS'(RES_Y - 1);
    localparam logic [X_BITS:0]       X_LAST_W = (X_BITS + 1)'(RES_X - 1);
    localparam logic [Y_BITS:0]       Y_LAST_W = (Y_BITS + 1)'(RES_Y - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(RES_X);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [X_BITS-1:0]     x_q,        x_d;         // current column
    logic [X_BITS-1:0]     x_start_q,  x_start_d;   // left edge, reloaded per row
    logic [X_BITS-1:0]     x_end_q,    x_end_d;     // right edge, inclusive
    logic [Y_BITS-1:0]     y_q,        y_d;         // current row
    logic [Y_BITS-1:0]     y_end_q,    y_end_d;     // bottom edge, inclusive
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;  // y_q * RES_X, kept incrementally
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_WIDTH-1:0]  din_q,      din_d;
    logic                  wen_q,      wen_d;
    logic                  swap_buf_q, swap_buf_d;
    logic                  cmd_err_q,  cmd_err_d;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic cmd_ready_int;
    logic cmd_accept;
    op_t  cmd_op;

    // Gated by rst so that cmd_ready reads 0 while reset is held and rises
    // as soon as reset releases (the state register is already IDLE).
    assign cmd_ready_int = rst && (state_q == ST_IDLE);
    assign cmd_accept    = bus.cmd_valid && cmd_ready_int;
    assign cmd_op        = op_t'(bus.cmd_op);

    // -----------------------------------------------------------------------
    // Command decode: build the normalised rectangle for the incoming
    // command and decide whether it is in range.
    // -----------------------------------------------------------------------
    logic [X_BITS:0]       rx0, rx1;
    logic [Y_BITS:0]       ry0, ry1;
    logic [X_BITS-1:0]     nx_lo, nx_hi;
    logic [Y_BITS-1:0]     ny_lo, ny_hi;
    logic                  range_err;
    logic [ADDR_WIDTH-1:0] first_row;

    always_comb begin
        rx0 = bus.cmd_x0;
        ry0 = bus.cmd_y0;
        rx1 = bus.cmd_x1;
        ry1 = bus.cmd_y1;

        // A PIXEL is a 1x1 rectangle; its x1/y1 inputs are don't-care.
        if (cmd_op == OP_PIXEL) begin
            rx1 = bus.cmd_x0;
            ry1 = bus.cmd_y0;
        end

`ifdef VGA_DRAW_CLIP_EN
        // Clamp each corner to the screen before normalising.
        range_err = 1'b0;
        if (rx0 > X_LAST_W) rx0 = X_LAST_W;
        if (rx1 > X_LAST_W) rx1 = X_LAST_W;
        if (ry0 > Y_LAST_W) ry0 = Y_LAST_W;
        if (ry1 > Y_LAST_W) ry1 = Y_LAST_W;
`else
        range_err = (rx0 > X_LAST_W) || (rx1 > X_LAST_W) ||
                    (ry0 > Y_LAST_W) || (ry1 > Y_LAST_W);
`endif

        // Normalise so that lo <= hi on both axes. When range_err is set
        // the truncated values below are never loaded.
        if (rx0 <= rx1) begin
            nx_lo = rx0[X_BITS-1:0];
            nx_hi = rx1[X_BITS-1:0];
        end else begin
            nx_lo = rx1[X_BITS-1:0];
            nx_hi = rx0[X_BITS-1:0];
        end
        if (ry0 <= ry1) begin
            ny_lo = ry0[Y_BITS-1:0];
            ny_hi = ry1[Y_BITS-1:0];
        end else begin
            ny_lo = ry1[Y_BITS-1:0];
            ny_hi = ry0[Y_BITS-1:0];
        end

        // CLEAR ignores all coordinates and covers the full screen.
        if (cmd_op == OP_CLEAR) begin
            nx_lo     = '0;
            nx_hi     = X_LAST;
            ny_lo     = '0;
            ny_hi     = Y_LAST;
            range_err = 1'b0;
        end

        // Only the starting row base needs y*RES_X. RES_X is a constant, so
        // this reduces to a few shifted adds; every later row is reached by
        // adding ROW_STEP.
        first_row = ADDR_WIDTH'(ny_lo) * ROW_STEP;
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        x_start_d  = x_start_q;
        x_end_d    = x_end_q;
        y_d        = y_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        mem_addr_d = mem_addr_q;
        din_d      = din_q;
        wen_d      = 1'b0;
        swap_buf_d = 1'b0;
        cmd_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_op == OP_SWAP) begin
                        swap_buf_d = 1'b1;
                        state_d    = ST_SWAP_REQ;
                    end else if (range_err) begin
                        cmd_err_d  = 1'b1;
                    end else begin
                        // Load the rectangle and issue the first write on
                        // the very next cycle.
                        x_d        = nx_lo;
                        x_start_d  = nx_lo;
                        x_end_d    = nx_hi;
                        y_d        = ny_lo;
                        y_end_d    = ny_hi;
                        row_base_d = first_row;
                        mem_addr_d = first_row + ADDR_WIDTH'(nx_lo);
                        din_d      = bus.cmd_color;
                        wen_d      = 1'b1;
                        state_d    = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                // The registered outputs currently present pixel (x_q, y_q);
                // work out the one after it.
                if (x_q == x_end_q) begin
                    if (y_q == y_end_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        x_d        = x_start_q;
                        y_d        = y_q + Y_BITS'(1);
                        row_base_d = row_base_q + ROW_STEP;
                        mem_addr_d = row_base_q + ROW_STEP + ADDR_WIDTH'(x_start_q);
                        wen_d      = 1'b1;
                    end
                end else begin
                    x_d        = x_q + X_BITS'(1);
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                    wen_d      = 1'b1;
                end
            end

            ST_SWAP_REQ: begin
                // swap_buf_q is high for this single cycle.
                state_d = ST_SWAP_WAIT;
            end

            ST_SWAP_WAIT: begin
                if (bus.swap_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            x_start_q  <= '0;
            x_end_q    <= '0;
            y_q        <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
            mem_addr_q <= '0;
            din_q      <= '0;
            wen_q      <= 1'b0;
            swap_buf_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            x_start_q  <= x_start_d;
            x_end_q    <= x_end_d;
            y_q        <= y_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
            mem_addr_q <= mem_addr_d;
            din_q      <= din_d;
            wen_q      <= wen_d;
            swap_buf_q <= swap_buf_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.cmd_ready = cmd_ready_int;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.din       = din_q;
    assign bus.wen       = wen_q;
    assign bus.swap_buf  = swap_buf_q;
    assign busy          = (state_q != ST_IDLE);
    assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_vga_draw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_draw_ctrl
//
// Self-checking bench for vga_draw_ctrl. A behavioural model computes the
// expected framebuffer writes of each command and pushes them to a queue;
// a monitor pops and compares one entry per observed wen cycle. Command
// latency, busy-cycle count, error pulses and the swap handshake are checked
// directly in the stimulus. Expectations follow VGA_DRAW_CLIP_EN when the
// bench is built with that macro.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_draw_ctrl;

    localparam int RES_X      = 320;
    localparam int RES_Y      = 240;
    localparam int MEM_WIDTH  = 8;
    localparam int ADDR_WIDTH = $clog2(RES_X * RES_Y);
    localparam int X_BITS     = $clog2(RES_X);
    localparam int Y_BITS     = $clog2(RES_Y);
    localparam int WAIT_LIMIT = 90000;

    localparam int OP_CLEAR = 0;
    localparam int OP_PIXEL = 1;
    localparam int OP_RECT  = 2;
    localparam int OP_SWAP  = 3;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic cmd_err;

    always #5 clk = ~clk;

    vga_draw_ctrl_if #(
        .X_BITS     (X_BITS),
        .Y_BITS     (Y_BITS),
        .MEM_WIDTH  (MEM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus ();

    vga_draw_ctrl #(
        .RES_X      (RES_X),
        .RES_Y      (RES_Y),
        .MEM_WIDTH  (MEM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .X_BITS     (X_BITS),
        .Y_BITS     (Y_BITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb_q[$];
    bit  sb_en = 1'b1;
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== 32'(exp)) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && sb_en && bus.wen === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", bus.mem_addr, -1);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.din, e.data);
            end
        end
    end

    // Reference model: push expected writes, report expected error.
    task automatic model_cmd(input int op, input int x0, input int y0,
                             input int x1, input int y1, input int color,
                             output int nwr, output int err);
        int xa, ya, xb, yb, t;
        nwr = 0;
        err = 0;
        xa = x0; ya = y0; xb = x1; yb = y1;
        if (op == OP_SWAP) return;
        if (op == OP_CLEAR) begin
            xa = 0; ya = 0; xb = RES_X - 1; yb = RES_Y - 1;
        end else begin
            if (op == OP_PIXEL) begin
                xb = xa;
                yb = ya;
            end
`ifdef VGA_DRAW_CLIP_EN
            if (xa > RES_X - 1) xa = RES_X - 1;
            if (xb > RES_X - 1) xb = RES_X - 1;
            if (ya > RES_Y - 1) ya = RES_Y - 1;
            if (yb > RES_Y - 1) yb = RES_Y - 1;
`else
            if (xa >= RES_X || xb >= RES_X || ya >= RES_Y || yb >= RES_Y) begin
                err = 1;
                return;
            end
`endif
            if (xa > xb) begin t = xa; xa = xb; xb = t; end
            if (ya > yb) begin t = ya; ya = yb; yb = t; end
        end
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                wr_t e;
                e.addr = y * RES_X + x;
                e.data = color;
                sb_q.push_back(e);
                nwr++;
            end
        end
    endtask

    task automatic drive_fields(input int op, input int x0, input int y0,
                                input int x1, input int y1, input int color);
        bus.cmd_op    = 2'(op);
        bus.cmd_x0    = (X_BITS + 1)'(x0);
        bus.cmd_y0    = (Y_BITS + 1)'(y0);
        bus.cmd_x1    = (X_BITS + 1)'(x1);
        bus.cmd_y1    = (Y_BITS + 1)'(y1);
        bus.cmd_color = MEM_WIDTH'(color);
    endtask

    // Present a command, wait for accept, scramble the inputs, then follow
    // the command until the sequencer is ready again.
    task automatic wait_accept(input string name);
        int w;
        w = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && w < WAIT_LIMIT) begin
            @(negedge clk);
            w++;
        end
        check({name, "_accept"}, bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        drive_fields($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 511),
                     $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 255));
    endtask

    task automatic send_cmd(input string name, input int op, input int x0, input int y0,
                            input int x1, input int y1, input int color);
        int nwr, err, n_wen, n_busy;
        model_cmd(op, x0, y0, x1, y1, color, nwr, err);
        drive_fields(op, x0, y0, x1, y1, color);
        wait_accept(name);
        @(negedge clk);
        check({name, "_first_wen"}, bus.wen, (nwr > 0) ? 1 : 0);
        check({name, "_err"}, cmd_err, err);
        n_wen  = 0;
        n_busy = 0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            if (bus.cmd_ready === 1'b1) break;
            n_busy++;
            if (bus.wen === 1'b1) n_wen++;
            @(negedge clk);
        end
        check({name, "_ready_after"}, bus.cmd_ready, 1);
        check({name, "_wen_cycles"}, n_wen, nwr);
        check({name, "_busy_cycles"}, n_busy, nwr);
        check({name, "_wen_low_at_ready"}, bus.wen, 0);
        @(negedge clk);
        check({name, "_err_pulse_end"}, cmd_err, 0);
        check({name, "_sb_drained"}, sb_q.size(), 0);
        $display("cmd %s op=%0d writes=%0d busy_cycles=%0d err=%0d",
                 name, op, n_wen, n_busy, err);
    endtask

    // SWAP with an early (ignored) swap_done during the request cycle and
    // the real swap_done 10 cycles later.
    task automatic send_swap(input string name);
        int hold_ok;
        drive_fields(OP_SWAP, 0, 0, 0, 0, 0);
        wait_accept(name);
        @(negedge clk);
        check({name, "_swap_buf_hi"}, bus.swap_buf, 1);
        check({name, "_busy_req"}, busy, 1);
        bus.swap_done = 1'b1;            // lands in SWAP_REQ: must be ignored
        @(negedge clk);
        bus.swap_done = 1'b0;
        check({name, "_swap_buf_one_cycle"}, bus.swap_buf, 0);
        hold_ok = 1;
        for (int i = 0; i < 9; i++) begin
            if (busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.swap_buf !== 1'b0) hold_ok = 0;
            @(negedge clk);
        end
        check({name, "_held_until_done"}, hold_ok, 1);
        bus.swap_done = 1'b1;
        @(negedge clk);
        bus.swap_done = 1'b0;
        check({name, "_busy_after_done"}, busy, 0);
        check({name, "_ready_after_done"}, bus.cmd_ready, 1);
        $display("cmd %s op=3 swap handshake complete", name);
    endtask

    initial begin
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.swap_done = 1'b0;
        drive_fields(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_wen_held", bus.wen, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wen", bus.wen, 0);
        check("rst_swap_buf", bus.swap_buf, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);

        send_cmd("pixel_5_2", OP_PIXEL, 5, 2, 300, 200, 8'h3F);
        send_cmd("rect_rev", OP_RECT, 2, 2, 1, 1, 8'h30);
        send_cmd("rect_3x4", OP_RECT, 10, 5, 12, 8, 8'h0C);
        send_cmd("rect_corner", OP_RECT, 319, 239, 318, 238, 8'h15);
        send_cmd("pixel_400_0", OP_PIXEL, 400, 0, 0, 0, 8'h2A);
        send_cmd("rect_y_oob", OP_RECT, 316, 237, 317, 240, 8'h01);

        // swap_done while idle must not disturb anything
        @(negedge clk);
        bus.swap_done = 1'b1;
        @(negedge clk);
        bus.swap_done = 1'b0;
        check("idle_swap_done_busy", busy, 0);
        check("idle_swap_done_ready", bus.cmd_ready, 1);

        send_swap("swap");
        send_cmd("clear", OP_CLEAR, 7, 7, 9, 9, 8'h00);
        send_cmd("pixel_after_clear", OP_PIXEL, 0, 239, 0, 0, 8'h03);

        // Reset in the middle of a CLEAR: writes stop at once, nothing resumes.
        sb_en = 1'b0;
        drive_fields(OP_CLEAR, 0, 0, 0, 0, 8'h11);
        wait_accept("clear_abort");
        repeat (50) @(negedge clk);
        check("abort_mid_fill_wen", bus.wen, 1);
        #1 rst = 1'b0;
        #1;
        check("abort_wen_drop", bus.wen, 0);
        check("abort_busy_drop", busy, 0);
        check("abort_swap_buf", bus.swap_buf, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        sb_en = 1'b1;
        @(negedge clk);
        check("abort_wen_after_release", bus.wen, 0);
        $display("cmd clear_abort reset applied mid-fill");
        send_cmd("pixel_0_0", OP_PIXEL, 0, 0, 5, 5, 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
